multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Moore-style sequencing controller for the multicycle version of our MIPS core. The core uses one unified instruction/data memory, a single ALU, and the IR/A/B/ALUOut/Data registers. Each cycle, the block decodes op/funct from the IR and drives every datapath mux select and write enable. Memory states wait on a ready handshake, guarded by a watchdog.

Parameters:
MEM_TIMEOUT, 16, max cycles spent waiting for mem_ready in one memory state before faulting; 0 disables the watchdog; legal range 0..255.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high; clock clk
op  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  unified memory has completed the current read/write
pcen  output  1  PC register enable = pcwrite | (branch & zero)
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  IR load enable
regdst  output  1  write register select: 0=rt, 1=rd
memtoreg  output  1  writeback data select: 0=ALUOut, 1=Data
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0=PC, 1=A
alusrcb  output  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10={PC[31:28],IR[25:0],00}, 11=A (jr)
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt
fault  output  2  00 none, 01 illegal instruction, 10 memory timeout; sticky
state  output  4  current state code, for debug

Behaviour:
- State register is 4 bits. Reset forces FETCH (0) and clears fault and the wait counter asynchronously.
- While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0. Other outputs take their FETCH values.
- Unlisted outputs are 0 in every state. alucontrol defaults to 010.
- FETCH(0): iord=0, alusrca=0, alusrcb=01, pcsrc=00. irwrite and pcwrite are both equal to mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE(1): alusrca=0, alusrcb=11 (precompute branch target). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 with funct 100000/100010/100100/100101/101010 -> EXECUTE
  - 000000 with funct 001000 -> JR
  - 000100 -> BRANCH
  - 001000/001100/001101/001110 -> IEXEC
  - 000010 -> JUMP
  - anything else -> ERROR, fault=01
- MEMADR(2): alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB(4): regdst=0, memtoreg=1, regwrite=1. -> FETCH.
- MEMWR(5): iord=1, memwrite=1, held every cycle until mem_ready. -> FETCH on mem_ready.
- EXECUTE(6): alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111). -> ALUWB.
- ALUWB(7): regdst=1, regwrite=1. -> FETCH.
- BRANCH(8): alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, so pcen=zero. -> FETCH.
- IEXEC(9): alusrca=1, alusrcb=10. alucontrol by op: addi 010, andi 000, ori 001, xori 011. -> IWB.
- IWB(10): regdst=0, memtoreg=0, regwrite=1. -> FETCH.
- JUMP(11): pcsrc=10, pcwrite=1. -> FETCH.
- JR(12): pcsrc=11, pcwrite=1, regwrite=0. -> FETCH.
- ERROR(13): all enables 0. Terminal until reset. Codes 14 and 15 are unreachable and are treated as ERROR.
- Watchdog:
  - An 8-bit wait counter clears on every state change and increments each cycle that FETCH, MEMRD or MEMWR is held with mem_ready=0.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is ERROR with fault=10.
  - mem_ready=1 in the same cycle the counter reaches its limit wins; no fault is raised.
- op and funct are sampled only in DECODE, EXECUTE and IEXEC. The datapath holds IR stable outside FETCH.
- Reset asserted mid-instruction aborts immediately and suppresses any pending register or memory write.
- Minimum latencies with mem_ready=1 every cycle:
  - lw: 5 cycles
  - sw, R-type, I-type ALU: 4 cycles
  - beq, j, jr: 3 cycles

Test Plan:
- lw, mem_ready always 1 -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. irwrite/pcen pulse once in cycle 0.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite held high for 4 cycles, iord=1 throughout, return to FETCH. fault=00.
- beq run twice, once with zero=1 and once with zero=0 -> pcen=1 with pcsrc=01 in BRANCH for the first; pcen=0 for the second.
- jr (op 000000, funct 001000) -> DECODE then JR: pcsrc=11, pcen=1, regwrite=0. xori -> IEXEC with alucontrol=011, then IWB with regwrite=1 and regdst=0.
- op 111111 -> ERROR with fault=01, all enables 0 for 20 cycles. Asserting reset returns to FETCH with fault=00.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR with fault=10 after 4 wait cycles. Reset mid-MEMWR -> memwrite drops to 0 asynchronously.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multicycle MIPS core: decodes op/funct per state,
// drives every datapath select and enable, and guards memory waits with a watchdog.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [1:0] fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IEXEC   = 4'd9,
    IWB     = 4'd10,
    JUMP    = 4'd11,
    JR      = 4'd12,
    ERROR   = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam bit         WDOG_EN       = (MEM_TIMEOUT != 0);
  localparam logic [7:0] WDOG_LIMIT    = MEM_TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic [1:0] fault_q, fault_d;
  logic       is_store_q, is_store_d;
  logic       pcwrite, branch;
  logic       irwrite_c, memwrite_c, regwrite_c;
  logic       mem_wait, timeout;

  // The watchdog trips on the cycle the counter sits at the limit; mem_ready in that cycle wins.
  assign timeout = WDOG_EN && !mem_ready && (wait_q == WDOG_LIMIT);

  // NOTE: every state-holding element uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_q     <= '0;
      fault_q    <= FAULT_NONE;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      is_store_q <= is_store_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_wait && wait_q != 8'hFF)
        wait_q <= wait_q + 8'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    is_store_d = is_store_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    mem_wait   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;

    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcwrite   = mem_ready;
        mem_wait  = !mem_ready;
        if (mem_ready) state_d = DECODE;
        else if (timeout) begin
          state_d = ERROR;
          fault_d = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011: begin state_d = MEMADR; is_store_d = 1'b0; end
          6'b101011: begin state_d = MEMADR; is_store_d = 1'b1; end
          6'b000000: begin
            case (funct)
              6'b100000, 6'b100010, 6'b100100,
              6'b100101, 6'b101010: state_d = EXECUTE;
              6'b001000:            state_d = JR;
              default: begin
                state_d = ERROR;
                fault_d = FAULT_ILLEGAL;
              end
            endcase
          end
          6'b000100:                                  state_d = BRANCH;
          6'b001000, 6'b001100, 6'b001101, 6'b001110: state_d = IEXEC;
          6'b000010:                                  state_d = JUMP;
          default: begin
            state_d = ERROR;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Load/store was latched in DECODE so op need not be looked at again here.
        state_d = is_store_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_wait = !mem_ready;
        if (mem_ready) state_d = MEMWB;
        else if (timeout) begin
          state_d = ERROR;
          fault_d = FAULT_TIMEOUT;
        end
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        mem_wait   = !mem_ready;
        if (mem_ready) state_d = FETCH;
        else if (timeout) begin
          state_d = ERROR;
          fault_d = FAULT_TIMEOUT;
        end
      end
      EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_d    = FETCH;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          6'b001100: alucontrol = ALU_AND;
          6'b001101: alucontrol = ALU_OR;
          6'b001110: alucontrol = ALU_XOR;
          default:   alucontrol = ALU_ADD;
        endcase
        state_d = IWB;
      end
      IWB: begin
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      JR: begin
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = ERROR;  // ERROR and the unused codes are terminal until reset
    endcase
  end

  // Reset must kill pending writes at once, not at the next edge.
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign irwrite  = irwrite_c & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign fault    = fault_q;
  assign state    = state_q;

endmodule
